alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//  Requester side of the ALU operand interface. Accepts one command {A, B, FUN} on a
//  valid/ready port and drives the ALU's A/B/ALU_FUN inputs. Samples the ALU's
//  combinational class flags and its registered ALU_OUT, then returns one response on a
//  valid/ready port. Rejects divide-by-zero and the unused opcode 4'b1111 without issuing.
// PARAMETERS
//  OPER_W     16  operand width (cmd_a/cmd_b/alu_a/alu_b)
//  OUT_W      32  result width (alu_out/rsp_result)
//  ERR_CNT_W   8  width of saturating reject counter err_count
// PORTS
//  CLK             in   1        clock, rising edge
//  RST             in   1        asynchronous reset, active low
//  cmd_valid       in   1        command present
//  cmd_ready       out  1        command accepted when cmd_valid & cmd_ready
//  cmd_a, cmd_b    in   OPER_W   operands
//  cmd_fun         in   4        ALU function code (0000..1110 valid)
//  alu_a, alu_b    out  OPER_W   registered operands to ALU
//  alu_fun         out  4        registered function to ALU; 4'b1111 = idle/no-op
//  alu_out         in   OUT_W    ALU registered result
//  alu_flags       in   4        {Arith, Logic, CMP, Shift} from ALU (combinational)
//  rsp_valid       out  1        response present
//  rsp_ready       in   1        response consumed when rsp_valid & rsp_ready
//  rsp_result      out  OUT_W    captured result (0 on reject)
//  rsp_flags       out  4        captured {Arith, Logic, CMP, Shift} (0 on reject)
//  rsp_err         out  1        1 = rejected command (div-by-zero or FUN=1111)
//  err_count       out  ERR_CNT_W  saturating count of rejected commands
// BEHAVIOUR
//  Reset: state IDLE.
//   - Zero: cmd_ready, rsp_valid, rsp_err, rsp_result, rsp_flags, alu_a, alu_b, err_count.
//   - alu_fun=4'b1111.
//   - Reset mid-operation drops the pending command; no response is produced.
//  FSM (one command in flight; cmd_ready=1 only in IDLE):
//   IDLE:    on cmd_valid, latch the command.
//            - Reject (cmd_fun==0011 & cmd_b==0, or cmd_fun==1111): rsp_err<=1,
//              rsp_result<=0, rsp_flags<=0, err_count+1 (saturate at all-ones), -> RESP.
//              alu_* are untouched.
//            - Otherwise: alu_a<=cmd_a, alu_b<=cmd_b, alu_fun<=cmd_fun, rsp_err<=0, -> ISSUE.
//   ISSUE:   alu_* stable; rsp_flags<=alu_flags at end of cycle (ALU registers ALU_OUT
//            at the same edge), -> CAPTURE.
//   CAPTURE: rsp_result<=alu_out, alu_fun<=4'b1111 (alu_a/alu_b hold), -> RESP.
//   RESP:    rsp_valid=1. rsp_result/rsp_flags/rsp_err held stable until rsp_ready=1,
//            then -> IDLE.
//  Latency (accept edge = N):
//   - Normal command: rsp_valid high after edge N+2.
//   - Rejected command: rsp_valid high after edge N.
//   - Best-case throughput: one command per 4 cycles (normal) or per 2 cycles (rejected).
//  Handshake rules:
//   - cmd_* are ignored outside IDLE.
//   - rsp_ready is ignored while rsp_valid=0.
//   - A new command may be accepted the cycle after the response handshake.
//  Arithmetic and width:
//   - Widths are passed through unchanged.
//   - rsp_result is the full OUT_W alu_out, not truncated.
//   - The block performs no arithmetic of its own except err_count.
// TESTING
//  1. a=0x1234, b=0x0101, fun=0000 -> rsp_result=0x00001335, rsp_flags=1000, rsp_err=0,
//     rsp_valid 2 cycles after accept.
//  2. a=0xFFFF, b=0xFFFF, fun=0010 -> rsp_result=0xFFFE0001, rsp_flags=1000.
//  3. a=5, b=0, fun=0011 -> rsp_err=1, rsp_result=0, rsp_flags=0, rsp_valid 1 cycle after
//     accept, alu_fun stays 1111, err_count=1.
//  4. a=7, b=3, fun=1011 with rsp_ready low for 5 cycles -> rsp_result=2, rsp_flags=0010
//     held stable, cmd_ready=0 throughout; after the handshake cmd_ready=1 next cycle.
//  5. RST low while in CAPTURE -> all outputs at reset values, no response; next command
//     a=0x00F0, b=0x000F, fun=0101 -> rsp_result=0x000000FF, rsp_flags=0100.
//  6. 260 back-to-back fun=1111 commands (ERR_CNT_W=8) -> err_count saturates at 255,
//     each receives rsp_err=1.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU-operand and response buses seen by the ALU command sequencer.
// "master" is the sequencer side; "slave" is the side that issues commands, hosts the ALU and
// consumes responses.
interface alu_cmd_sequencer_if #(
  parameter int OPER_W    = 16,
  parameter int OUT_W     = 32,
  parameter int ERR_CNT_W = 8
);
  // command port
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OPER_W-1:0]    cmd_a;
  logic [OPER_W-1:0]    cmd_b;
  logic [3:0]           cmd_fun;
  // ALU operand side
  logic [OPER_W-1:0]    alu_a;
  logic [OPER_W-1:0]    alu_b;
  logic [3:0]           alu_fun;
  logic [OUT_W-1:0]     alu_out;
  logic [3:0]           alu_flags;
  // response port
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_W-1:0]     rsp_result;
  logic [3:0]           rsp_flags;
  logic                 rsp_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, alu_out, alu_flags, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_fun, rsp_valid, rsp_result, rsp_flags, rsp_err,
           err_count
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, alu_out, alu_flags, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_fun, rsp_valid, rsp_result, rsp_flags, rsp_err,
           err_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: takes one {A, B, FUN} command at a time, drives it onto the ALU's
// registered operand inputs, captures the ALU class flags and registered result, and returns
// a single response. Divide-by-zero and the unused opcode 1111 are answered immediately with
// an error response and never reach the ALU.
module alu_cmd_sequencer #(
  parameter int OPER_W    = 16,
  parameter int OUT_W     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic            CLK,
  input  logic            RST,
  alu_cmd_sequencer_if.master bus
);

  localparam logic [3:0] FUN_DIV = 4'b0011;
  localparam logic [3:0] FUN_NOP = 4'b1111;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  // operands presented to the ALU
  typedef struct packed {
    logic [OPER_W-1:0] a;
    logic [OPER_W-1:0] b;
    logic [3:0]        fun;
  } op_t;

  // response payload, held stable while rsp_valid is high
  typedef struct packed {
    logic [OUT_W-1:0] result;
    logic [3:0]       flags;
    logic             err;
  } rsp_t;

  state_e               state_q, state_d;
  op_t                  alu_q, alu_d;
  rsp_t                 rsp_q, rsp_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 reject;

  // Commands the ALU must never see: divide by zero and the idle opcode.
  assign reject = (bus.cmd_fun == FUN_NOP) ||
                  ((bus.cmd_fun == FUN_DIV) && (bus.cmd_b == '0));

  // Next-state and datapath updates; everything holds unless a state says otherwise.
  always_comb begin
    state_d   = state_q;
    alu_d     = alu_q;
    rsp_d     = rsp_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q is only ever high in IDLE, so this is the accept condition
        if (cmd_ready_q && bus.cmd_valid) begin
          if (reject) begin
            rsp_d.result = '0;
            rsp_d.flags  = '0;
            rsp_d.err    = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            state_d = RESP;
          end else begin
            alu_d.a   = bus.cmd_a;
            alu_d.b   = bus.cmd_b;
            alu_d.fun = bus.cmd_fun;
            rsp_d.err = 1'b0;
            state_d   = ISSUE;
          end
        end
      end

      ISSUE: begin
        // class flags are combinational from alu_fun; the ALU registers its result this edge
        rsp_d.flags = bus.alu_flags;
        state_d     = CAPTURE;
      end

      CAPTURE: begin
        // operands hold so the ALU keeps reading the same values; only the opcode idles
        rsp_d.result = bus.alu_out;
        alu_d.fun    = FUN_NOP;
        state_d      = RESP;
      end

      RESP: begin
        // rsp_valid_q is high for the whole of RESP, so rsp_ready alone completes it
        if (bus.rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // handshake flags are registered so they are clean (and low) straight out of reset
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and datapath registers; reset drops any command in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      alu_q       <= '{a: '0, b: '0, fun: FUN_NOP};
      rsp_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alu_q       <= alu_d;
      rsp_q       <= rsp_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_a      = alu_q.a;
  assign bus.alu_b      = alu_q.b;
  assign bus.alu_fun    = alu_q.fun;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_q.result;
  assign bus.rsp_flags  = rsp_q.flags;
  assign bus.rsp_err    = rsp_q.err;
  assign bus.err_count  = err_cnt_q;

endmodule
